nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract unit. Processes one 4-bit nibble per clock, LSB nibble first, through a registered ripple carry.
- Sits directly upstream of the ALU lookahead-carry stage. Besides the sum and carry-out, it emits word-level active-low group generate/propagate (go_n/po_n) in the same polarity that stage consumes.
- Valid/ready handshake on both input and output, so it can share a datapath with single-cycle ALU slices.

---
 rtl/nibble_serial_adder.sv | 135 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract, one nibble per clock LSB first; emits active-low word group generate/propagate.
// Optional ovf output under NIBBLE_ADDER_OVF_EN. Result NIB+1 cycles after accept; holds in DONE until out_ready.
module nibble_serial_adder #(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cn,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cnx,
    output logic             go_n,
`ifdef NIBBLE_ADDER_OVF_EN
    output logic             po_n,
    output logic             ovf
`else
    output logic             po_n
`endif
);

    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             gacc, pacc;

    logic [3:0]       na, nb, g, p, ns;
    logic             nc, ng, np, g_new, p_new, last;

    assign na = a_r[{idx, 2'b00} +: 4];
    assign nb = b_r[{idx, 2'b00} +: 4];
    assign {nc, ns} = {1'b0, na} + {1'b0, nb} + {4'b0000, carry};
    assign g  = na & nb;
    assign p  = na | nb;
    assign ng = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign np = &p;
    // Each new nibble is more significant than everything accumulated so far.
    assign g_new = ng | (np & gacc);
    assign p_new = pacc & np;
    assign last  = (idx == IW'(NIB - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            gacc  <= 1'b0;
            pacc  <= 1'b1;
            sum   <= '0;
            cnx   <= 1'b0;
            go_n  <= 1'b1;
            po_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b ^ {WIDTH{sub}};
                        carry <= cn;
                        idx   <= '0;
                        gacc  <= 1'b0;
                        pacc  <= 1'b1;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= ns;
                    carry <= nc;
                    gacc  <= g_new;
                    pacc  <= p_new;
                    idx   <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cnx  <= nc;
                        go_n <= ~g_new;
                        po_n <= ~p_new;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NIBBLE_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= (na[3] ^ nb[3] ^ ns[3]) ^ nc;
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed table-driven bench for nibble_serial_adder (WIDTH=16), plus stall, abort and overflow sequences.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cn, sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] sum;
    logic             cnx, go_n, po_n;
`ifdef NIBBLE_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cn(cn), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cnx(cnx), .go_n(go_n),
`ifdef NIBBLE_ADDER_OVF_EN
        .po_n(po_n), .ovf(ovf)
`else
        .po_n(po_n)
`endif
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cn, sub;
        logic [15:0] e_sum;
        logic        e_cnx, e_go_n, e_po_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE and wait for out_valid. lat = edges from the handshake
    // edge to the first edge at which out_valid is sampled high.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tcn, input logic tsub, output int lat);
        @(negedge clk);
        a = ta; b = tb_; cn = tcn; sub = tsub; in_valid = 1'b1;
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) begin
                lat = k + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", 32'(out_valid), 32'd0);
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[6];
    int   lat;
    logic seen;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        // All-propagate word with cn=1: carry out comes only from cn, so go_n stays 1.
        vecs[5] = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cn = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cnx", 32'(cnx), 32'd0);
        chk("rst_go_n", 32'(go_n), 32'd1);
        chk("rst_po_n", 32'(po_n), 32'd1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cn, vecs[i].sub, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].e_sum));
            chk($sformatf("v%0d_cnx", i), 32'(cnx), 32'(vecs[i].e_cnx));
            chk($sformatf("v%0d_go_n", i), 32'(go_n), 32'(vecs[i].e_go_n));
            chk($sformatf("v%0d_po_n", i), 32'(po_n), 32'(vecs[i].e_po_n));
            chk($sformatf("v%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            release_out();
            chk($sformatf("v%0d_sum_held_idle", i), 32'(sum), 32'(vecs[i].e_sum));
        end

        // Output stall with a pending request: nothing moves until the result is taken.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        a = 16'h0100; b = 16'h0200; cn = 1'b0; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_sum", 32'(sum), 32'h3333);
            chk("stall_go_n", 32'(go_n), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_idle_in_ready", 32'(in_ready), 32'd1);
        chk("stall_idle_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_second_accept", 32'(in_ready), 32'd0);
        chk("stall_sum_cleared", 32'(sum), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("stall_second_done", 32'(seen), 32'd1);
        chk("stall_second_sum", 32'(sum), 32'h0300);
        release_out();

        // Reset in the middle of RUN (nibble index 2) aborts the op.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cn = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_po_n", 32'(po_n), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_out_valid", 32'(seen), 32'd0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        chk("abort_new_latency", 32'(lat), 32'd5);
        chk("abort_new_sum", 32'(sum), 32'h0002);
        chk("abort_new_cnx", 32'(cnx), 32'd0);
        release_out();

`ifdef NIBBLE_ADDER_OVF_EN
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("ovf_pos_ovf", 32'(ovf), 32'd1);
        chk("ovf_pos_cnx", 32'(cnx), 32'd0);
        chk("ovf_pos_sum", 32'(sum), 32'h8000);
        release_out();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("ovf_wrap_ovf", 32'(ovf), 32'd0);
        chk("ovf_wrap_cnx", 32'(cnx), 32'd1);
        release_out();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
